pci_initiator: RTL and testbench
================================

# pci_initiator

Bus-master (initiator) front end for the PCI bus. It sits between a local user port and the shared bus. It asserts REQ toward the central arbiter and waits for GNT with the bus idle. It then drives the address phase, runs a burst of 1–16 single-DWORD data phases with FRAME/IRDY signalling, and releases the bus. It is the requesting-agent counterpart to the arbiter's REQ/GNT/FRAME logic.

## Interface
Parameters:
- MAX_BURST, 16, maximum data phases per transaction; `len` is clamped to this value.
- DEVSEL_TIMEOUT, 5, clocks after FRAME assertion without DEVSEL before master abort.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; accepted only while `busy`=0.
- cmd  input  4  PCI command; cmd[0]=1 means write, cmd[0]=0 means read.
- addr  input  32  start address.
- len  input  5  number of data phases. 0 is treated as 1; values above MAX_BURST are clamped.
- wr_data  input  32  current write word; the user holds it stable and advances on wr_ack.
- wr_ack  output  1  high for the cycle in which wr_data is latched onto AD.
- rd_data  output  32  captured read word.
- rd_valid  output  1  one-cycle strobe per completed read phase.
- busy / done / abort  output  1 each. `done` and `abort` are one-cycle pulses.
- REQ  output  1  active-low bus request.
- GNT  input  1  active-low grant.
- FRAME, IRDY  output  1 each, active-low.
- TRDY, DEVSEL  input  1 each, active-low.
- AD_out  output  32, AD_oe  output  1, AD_in  input  32: split AD bus.
- CBE  output  4  command / byte enables.

## Operation
- States: IDLE, REQ_WAIT, ADDR, DATA, TURN.
- IDLE
  - On `start`, latch cmd, addr and len (after clamp), set busy=1, go to REQ_WAIT.
- REQ_WAIT
  - Drive REQ=0.
  - Go to ADDR when sampled GNT=0, FRAME_in idle and IRDY idle. Bus-idle inputs come from the bus monitor; tie them high when unused.
  - If GNT deasserts, stay in REQ_WAIT.
- ADDR (one cycle)
  - FRAME=0, AD_oe=1, AD_out=addr, CBE=cmd, REQ=1.
  - For writes, also preload word 0 into the AD register with wr_ack=1.
- DATA
  - IRDY=0, CBE=4'b0000.
  - Write: AD_oe=1. Read: AD_oe=0 for the whole phase, which gives the turnaround.
  - A phase completes when IRDY=0 and TRDY=0 are seen on the same edge. Then decrement the remaining count.
    - Read: capture AD_in into rd_data and pulse rd_valid.
    - Write with words remaining: latch the next wr_data and pulse wr_ack.
  - FRAME goes to 1 during the final phase, i.e. once remaining==1, including a single-phase transfer.
  - After the last completion, go to TURN.
- TURN (one cycle)
  - IRDY=1, FRAME=1, AD_oe=0, CBE=4'hF. Pulse `done`, clear busy, go to IDLE.
- GNT removed during DATA: the burst continues. There is no latency timer.
- Target STOP and retry are not supported.
- Reset (RST=0 at an edge) wins over everything, including mid-burst.
  - Outputs after reset: REQ=1, FRAME=1, IRDY=1, AD_oe=0, AD_out=0, CBE=4'hF, wr_ack=0, rd_valid=0, rd_data=0, busy=0, done=0, abort=0.
  - State after reset: IDLE.
- `start` while busy is ignored.

## Timing
- Registered outputs: REQ changes one cycle after `start`. FRAME asserts one cycle after GNT=0 is sampled.
- Minimum write of one word: start → REQ (+1) → FRAME (+1 after GNT) → IRDY (+1) → completion on the first TRDY=0 → TURN → IDLE. That is 5 cycles with zero-wait GNT and TRDY.
- Wait states: IRDY stays 0 and AD_out stays constant while TRDY=1.
- DEVSEL is counted from the ADDR cycle. If no DEVSEL=0 has been seen by DEVSEL_TIMEOUT cycles, perform a master abort (see Configuration).

## Configuration
- PCI_MASTER_ABORT_EN defined:
  - A DEVSEL timeout counter is compiled in.
  - On timeout: drive FRAME=1, then one cycle later IRDY=1, then TURN.
  - Pulse `abort` (not `done`). No rd_valid is issued.
- PCI_MASTER_ABORT_EN undefined:
  - No counter. The initiator waits indefinitely for TRDY.
  - `abort` is tied to 0.

## Test plan
- Single write: cmd=4'b0111, addr=32'h1000, len=1, GNT=0 immediately, TRDY=0 in the first data phase → AD_out=32'h1000 with CBE=0111, then one wr_ack. FRAME is low 1 cycle, IRDY low 1 cycle, `done` 5 cycles after start.
- 4-word read, TRDY wait state on phase 2: cmd=4'b0110, target returns 0xA0..0xA3 → four rd_valid pulses with matching rd_data. FRAME rises with the 4th IRDY phase. AD_oe=0 throughout DATA.
- Late grant: GNT held high 10 cycles → REQ stays 0, FRAME stays 1. FRAME asserts exactly one cycle after GNT=0.
- Grant lost before address: GNT 0 for one cycle while the bus is busy, then 1 → no FRAME. The initiator stays in REQ_WAIT.
- Master abort (macro defined): DEVSEL held 1 → FRAME deasserts at timeout, then IRDY, then `abort` pulses. `done` stays 0 and busy clears.
- Reset mid-burst: RST=0 during phase 2 of a 4-word write → next edge has all outputs at their reset values. A new start then proceeds normally.

Source files
------------

// File: rtl/pci_initiator.sv
// PCI bus-master front end: REQ/GNT arbitration, address phase and 1..MAX_BURST data phases.
// Optional DEVSEL master-abort logic is compiled in when PCI_MASTER_ABORT_EN is defined.
module pci_initiator #(
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [4:0]  len,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        REQ,
    input  logic        GNT,
    input  logic        FRAME_in,
    input  logic        IRDY_in,
    output logic        FRAME,
    output logic        IRDY,
    input  logic        TRDY,
    input  logic        DEVSEL,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    input  logic [31:0] AD_in,
    output logic [3:0]  CBE
);

    localparam int unsigned LEN_W = 5;
    localparam int unsigned AD_W  = 32;
    localparam int unsigned CBE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ADDR,
        S_DATA,
        S_TURN,
        S_ABORT
    } state_t;

    state_t state;
    state_t next_state;

    logic [CBE_W-1:0] cmd_q;
    logic [AD_W-1:0]  addr_q;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_after;
    logic [LEN_W-1:0] len_eff;

    logic is_write;
    logic complete;
    logic last;
    logic timeout;
    logic aborted;

    logic             req_d;
    logic             frame_d;
    logic             irdy_d;
    logic             ad_oe_d;
    logic [AD_W-1:0]  ad_out_d;
    logic [CBE_W-1:0] cbe_d;
    logic [AD_W-1:0]  rd_data_d;
    logic             rd_valid_d;
    logic             busy_d;
    logic             done_d;
    logic             abort_d;

    assign is_write = cmd_q[0];
    assign complete = (state == S_DATA) && !IRDY && !TRDY;
    assign last     = (rem == LEN_W'(1));

    // Zero-length requests become one phase; oversize requests are clipped.
    always_comb begin
        len_eff = len;
        if (len == '0) begin
            len_eff = LEN_W'(1);
        end else if (32'(len) > MAX_BURST) begin
            len_eff = LEN_W'(MAX_BURST);
        end
    end

    // Transaction parameters and remaining-phase counter.
    always_ff @(posedge clk) begin
        if (!RST) begin
            cmd_q  <= '0;
            addr_q <= '0;
            rem    <= '0;
        end else if (state == S_IDLE && start) begin
            cmd_q  <= cmd;
            addr_q <= addr;
            rem    <= len_eff;
        end else if (complete) begin
            rem <= rem - LEN_W'(1);
        end
    end

`ifdef PCI_MASTER_ABORT_EN
    localparam int unsigned CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

    logic [CNT_W-1:0] dev_cnt;
    logic             dev_seen;

    // Cycles since the address phase began; saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (!RST) begin
            dev_cnt  <= '0;
            dev_seen <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            if (state == S_REQ_WAIT) begin
                dev_cnt  <= '0;
                dev_seen <= 1'b0;
            end else if (state == S_ADDR || state == S_DATA) begin
                if (!DEVSEL) begin
                    dev_seen <= 1'b1;
                end
                if (dev_cnt != CNT_W'(DEVSEL_TIMEOUT)) begin
                    dev_cnt <= dev_cnt + CNT_W'(1);
                end
            end
            if (state == S_IDLE && start) begin
                aborted <= 1'b0;
            end else if (state == S_DATA && next_state == S_ABORT) begin
                aborted <= 1'b1;
            end
        end
    end

    assign timeout = (state == S_DATA) && !dev_seen && DEVSEL &&
                     (dev_cnt >= CNT_W'(DEVSEL_TIMEOUT - 1));
`else
    logic unused_devsel;

    assign unused_devsel = DEVSEL;
    assign timeout       = 1'b0;
    assign aborted       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_REQ_WAIT;
                end
            end
            S_REQ_WAIT: begin
                if (!GNT && FRAME_in && IRDY_in) begin
                    next_state = S_ADDR;
                end
            end
            S_ADDR: next_state = S_DATA;
            S_DATA: begin
                if (complete && last) begin
                    next_state = S_TURN;
                end else if (timeout) begin
                    next_state = S_ABORT;
                end
            end
            S_ABORT: next_state = S_TURN;
            S_TURN:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: next values for the bus registers, plus the write-accept strobe.
    always_comb begin
        req_d      = 1'b1;
        frame_d    = 1'b1;
        irdy_d     = 1'b1;
        ad_oe_d    = 1'b0;
        ad_out_d   = AD_out;
        cbe_d      = '1;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        wr_ack     = 1'b0;
        rem_after  = complete ? (rem - LEN_W'(1)) : rem;

        case (next_state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (state == S_TURN) begin
                    done_d  = !aborted;
                    abort_d = aborted;
                end
            end
            S_REQ_WAIT: req_d = 1'b0;
            S_ADDR: begin
                frame_d  = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
                cbe_d    = cmd_q;
            end
            S_DATA: begin
                frame_d = (rem_after == LEN_W'(1));
                irdy_d  = 1'b0;
                cbe_d   = '0;
                ad_oe_d = is_write;
            end
            S_ABORT: begin
                irdy_d  = 1'b0;
                cbe_d   = '0;
                ad_oe_d = is_write;
            end
            default: ;
        endcase

        // Word 0 is preloaded during the address phase; later words on each non-final completion.
        if (is_write && (state == S_ADDR || (complete && !last))) begin
            wr_ack   = 1'b1;
            ad_out_d = wr_data;
        end

        if (complete && !is_write) begin
            rd_data_d  = AD_in;
            rd_valid_d = 1'b1;
        end
    end

    // Bus-facing output registers.
    always_ff @(posedge clk) begin
        if (!RST) begin
            REQ      <= 1'b1;
            FRAME    <= 1'b1;
            IRDY     <= 1'b1;
            AD_oe    <= 1'b0;
            AD_out   <= '0;
            CBE      <= '1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            REQ      <= req_d;
            FRAME    <= frame_d;
            IRDY     <= irdy_d;
            AD_oe    <= ad_oe_d;
            AD_out   <= ad_out_d;
            CBE      <= cbe_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            abort    <= abort_d;
        end
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: writes, reads with wait states, arbitration, clamping,
// DEVSEL handling (both builds of PCI_MASTER_ABORT_EN) and reset during a burst.
module tb_pci_initiator;

    logic        clk;
    logic        RST;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [4:0]  len;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        abort;
    logic        REQ;
    logic        GNT;
    logic        FRAME_in;
    logic        IRDY_in;
    logic        FRAME;
    logic        IRDY;
    logic        TRDY;
    logic        DEVSEL;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic [31:0] AD_in;
    logic [3:0]  CBE;

    int total = 0;
    int bad   = 0;
    int nrd;
    logic done_seen;

    pci_initiator dut (
        .clk      (clk),
        .RST      (RST),
        .start    (start),
        .cmd      (cmd),
        .addr     (addr),
        .len      (len),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .abort    (abort),
        .REQ      (REQ),
        .GNT      (GNT),
        .FRAME_in (FRAME_in),
        .IRDY_in  (IRDY_in),
        .FRAME    (FRAME),
        .IRDY     (IRDY),
        .TRDY     (TRDY),
        .DEVSEL   (DEVSEL),
        .AD_out   (AD_out),
        .AD_oe    (AD_oe),
        .AD_in    (AD_in),
        .CBE      (CBE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // REQ FRAME IRDY AD_oe CBE[3:0] wr_ack rd_valid busy done abort
    task automatic chk_reset_outs(input string tag);
        chk32({tag, "_ctl"}, 32'({REQ, FRAME, IRDY, AD_oe, CBE, wr_ack, rd_valid, busy, done, abort}),
              32'(13'b1110111100000));
        chk32({tag, "_ad"}, AD_out, 32'h0);
        chk32({tag, "_rd"}, rd_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; len = 5'd0; wr_data = 32'h0;
        GNT = 1'b1; FRAME_in = 1'b1; IRDY_in = 1'b1; TRDY = 1'b1; DEVSEL = 1'b1; AD_in = 32'h0;
        tick();
        tick();
        chk_reset_outs("reset");
        RST = 1'b1;
        tick();
        chk1("idle_busy", busy, 1'b0);

        // Single-word write, zero-wait grant and target.
        cmd = 4'b0111; addr = 32'h1000; len = 5'd1; wr_data = 32'hDEAD0001;
        GNT = 1'b0; DEVSEL = 1'b0; TRDY = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("w1_req", REQ, 1'b0);
        chk1("w1_frame_rw", FRAME, 1'b1);
        chk1("w1_busy", busy, 1'b1);
        tick();
        chk1("w1_frame_addr", FRAME, 1'b0);
        chk32("w1_ad_addr", AD_out, 32'h1000);
        chk32("w1_cbe_addr", 32'(CBE), 32'h7);
        chk1("w1_oe_addr", AD_oe, 1'b1);
        chk1("w1_req_rel", REQ, 1'b1);
        chk1("w1_wr_ack_addr", wr_ack, 1'b1);
        tick();
        chk1("w1_irdy", IRDY, 1'b0);
        chk1("w1_frame_last", FRAME, 1'b1);
        chk32("w1_ad_data", AD_out, 32'hDEAD0001);
        chk32("w1_cbe_data", 32'(CBE), 32'h0);
        chk1("w1_wr_ack_data", wr_ack, 1'b0);
        tick();
        chk1("w1_irdy_turn", IRDY, 1'b1);
        chk32("w1_cbe_turn", 32'(CBE), 32'hF);
        chk1("w1_oe_turn", AD_oe, 1'b0);
        chk1("w1_done_early", done, 1'b0);
        tick();
        chk1("w1_done", done, 1'b1);
        chk1("w1_busy_clr", busy, 1'b0);
        tick();
        chk1("w1_done_pulse", done, 1'b0);

        // Four-word read with one wait state on phase 2.
        cmd = 4'b0110; addr = 32'h2000; len = 5'd4; TRDY = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk32("r4_cbe_addr", 32'(CBE), 32'h6);
        chk32("r4_ad_addr", AD_out, 32'h2000);
        chk1("r4_no_wr_ack", wr_ack, 1'b0);
        TRDY = 1'b0; AD_in = 32'hA0;
        tick();
        chk1("r4_irdy", IRDY, 1'b0);
        chk1("r4_oe_p1", AD_oe, 1'b0);
        chk1("r4_frame_p1", FRAME, 1'b0);
        tick();
        chk1("r4_valid0", rd_valid, 1'b1);
        chk32("r4_data0", rd_data, 32'hA0);
        TRDY = 1'b1;
        tick();
        chk1("r4_wait_valid", rd_valid, 1'b0);
        chk1("r4_wait_irdy", IRDY, 1'b0);
        chk1("r4_wait_oe", AD_oe, 1'b0);
        TRDY = 1'b0; AD_in = 32'hA1;
        tick();
        chk1("r4_valid1", rd_valid, 1'b1);
        chk32("r4_data1", rd_data, 32'hA1);
        chk1("r4_frame_p3", FRAME, 1'b0);
        AD_in = 32'hA2;
        tick();
        chk32("r4_data2", rd_data, 32'hA2);
        chk1("r4_frame_p4", FRAME, 1'b1);
        chk1("r4_irdy_p4", IRDY, 1'b0);
        AD_in = 32'hA3;
        tick();
        chk1("r4_valid3", rd_valid, 1'b1);
        chk32("r4_data3", rd_data, 32'hA3);
        chk1("r4_irdy_turn", IRDY, 1'b1);
        tick();
        chk1("r4_done", done, 1'b1);
        TRDY = 1'b1;

        // Late grant, then a two-word write with a wait state on phase 1.
        GNT = 1'b1; cmd = 4'b0111; addr = 32'h3000; len = 5'd2; wr_data = 32'h11110000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("lg_req", REQ, 1'b0);
            chk1("lg_frame", FRAME, 1'b1);
        end
        GNT = 1'b0;
        tick();
        chk1("lg_frame_addr", FRAME, 1'b0);
        chk1("lg_wr_ack_addr", wr_ack, 1'b1);
        tick();
        wr_data = 32'h11110001;
        chk32("lg_ad_w0", AD_out, 32'h11110000);
        chk1("lg_frame_p1", FRAME, 1'b0);
        chk1("lg_wr_ack_wait", wr_ack, 1'b0);
        tick();
        chk32("lg_ad_hold", AD_out, 32'h11110000);
        chk1("lg_irdy_hold", IRDY, 1'b0);
        TRDY = 1'b0;
        #1;
        chk1("lg_wr_ack_p1", wr_ack, 1'b1);
        tick();
        wr_data = 32'h11110002;
        chk32("lg_ad_w1", AD_out, 32'h11110001);
        chk1("lg_frame_p2", FRAME, 1'b1);
        chk1("lg_wr_ack_last", wr_ack, 1'b0);
        tick();
        tick();
        chk1("lg_done", done, 1'b1);
        TRDY = 1'b1;

        // Grant while the bus is busy, then grant lost; len=0 behaves as one phase.
        cmd = 4'b0110; addr = 32'h4000; len = 5'd0; FRAME_in = 1'b0; GNT = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk1("gl_frame_busybus", FRAME, 1'b1);
        chk1("gl_req_busybus", REQ, 1'b0);
        GNT = 1'b1; FRAME_in = 1'b1;
        cmd = 4'b0111; addr = 32'h9999; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("gl_frame_lost", FRAME, 1'b1);
        chk1("gl_req_lost", REQ, 1'b0);
        chk1("gl_busy", busy, 1'b1);
        tick();
        chk1("gl_frame_lost2", FRAME, 1'b1);
        GNT = 1'b0;
        tick();
        chk1("gl_frame_addr", FRAME, 1'b0);
        chk32("gl_cbe_kept", 32'(CBE), 32'h6);
        chk32("gl_addr_kept", AD_out, 32'h4000);
        AD_in = 32'h55; TRDY = 1'b0;
        tick();
        chk1("gl_frame_single", FRAME, 1'b1);
        tick();
        chk1("gl_valid", rd_valid, 1'b1);
        chk32("gl_data", rd_data, 32'h55);
        tick();
        chk1("gl_done", done, 1'b1);

        // Oversize length is clipped to 16 phases.
        cmd = 4'b0110; addr = 32'h8000; len = 5'd31; TRDY = 1'b0; start = 1'b1;
        nrd = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            start = 1'b0;
            if (rd_valid) nrd++;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
        end
        chk1("clamp_done", done_seen, 1'b1);
        chk32("clamp_phases", 32'(nrd), 32'd16);
        TRDY = 1'b1;

        // DEVSEL never asserted by the target.
        cmd = 4'b0111; addr = 32'h5000; len = 5'd2; wr_data = 32'h22220000; DEVSEL = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
`ifdef PCI_MASTER_ABORT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("ma_frame_wait", FRAME, 1'b0);
            chk1("ma_irdy_wait", IRDY, 1'b0);
        end
        tick();
        chk1("ma_frame_rel", FRAME, 1'b1);
        chk1("ma_irdy_held", IRDY, 1'b0);
        tick();
        chk1("ma_irdy_rel", IRDY, 1'b1);
        chk1("ma_abort_early", abort, 1'b0);
        tick();
        chk1("ma_abort", abort, 1'b1);
        chk1("ma_no_done", done, 1'b0);
        chk1("ma_busy_clr", busy, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("nd_irdy_wait", IRDY, 1'b0);
            chk1("nd_abort", abort, 1'b0);
        end
        TRDY = 1'b0;
        #1;
        chk1("nd_wr_ack", wr_ack, 1'b1);
        tick();
        chk1("nd_frame_last", FRAME, 1'b1);
        tick();
        tick();
        chk1("nd_done", done, 1'b1);
        chk1("nd_abort_end", abort, 1'b0);
`endif
        DEVSEL = 1'b0; TRDY = 1'b1;
        tick();

        // Reset in phase 2 of a four-word write, then a fresh transaction.
        cmd = 4'b0111; addr = 32'h6000; len = 5'd4; wr_data = 32'h33330000; TRDY = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk1("rm_in_phase2", IRDY, 1'b0);
        RST = 1'b0;
        tick();
        chk_reset_outs("rm");
        RST = 1'b1;
        cmd = 4'b0111; addr = 32'h7000; len = 5'd1; wr_data = 32'h44440000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk32("rm_new_addr", AD_out, 32'h7000);
        chk1("rm_new_frame", FRAME, 1'b0);
        tick();
        tick();
        tick();
        chk1("rm_new_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
